mul_hilo_unit: RTL and testbench
================================

Name: mul_hilo_unit

Overview:
- Multi-cycle issue/capture stage wrapped around the KGP-RISC ALU's combinational 32x32->64 multiplier.
- Upstream side: latches operands on a start request and holds them stable on the multiplier inputs for a fixed settle window, so the multiplier is timed as a multicycle path.
- Downstream side: captures the 64-bit product into architectural HI/LO registers and exposes them to the datapath, together with direct HI/LO write ports (move-to-HI, move-to-LO).

Parameters:
- SETTLE_CYCLES, 2, cycles operands are held before product capture; legal range 1..15.
- CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  multiply request; sampled only in IDLE.
- op_a  input  32  multiplier operand, latched when start is accepted.
- op_b  input  32  multiplicand operand, latched when start is accepted.
- mul_a  output  32  registered operand driven to the combinational multiplier.
- mul_b  output  32  registered operand driven to the combinational multiplier.
- mul_product  input  64  unsigned product returned by the multiplier.
- busy  output  1  high while a multiply is in flight.
- done  output  1  one-cycle pulse after HI/LO capture.
- hi  output  32  HI register.
- lo  output  32  LO register.
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  32  data for mthi/mtlo.
- wr_err  output  1  one-cycle pulse when an mthi/mtlo was dropped because busy was high.

Behaviour:
- Reset: state=IDLE; counter=0; mul_a, mul_b, hi, lo = 0; busy, done, wr_err = 0. Reset mid-operation aborts the multiply with no capture, and HI/LO return to 0.
- States: IDLE, SETTLE.
- IDLE with start=1 at edge E0:
  - mul_a<=op_a and mul_b<=op_b.
  - counter<=SETTLE_CYCLES-1.
  - state<=SETTLE and busy<=1.
- SETTLE at each edge:
  - If counter!=0: decrement the counter.
  - If counter==0: {hi,lo}<=mul_product (corrected, see the optional feature); state<=IDLE; busy<=0; done<=1 for exactly one cycle.
  - Capture therefore occurs at edge E_SETTLE_CYCLES. Operands are stable for SETTLE_CYCLES full cycles before capture.
- mul_a and mul_b hold their values after completion until the next accepted start.
- start while busy is ignored and not queued.
- Back-to-back operation: start is accepted in the cycle done is high (state is already IDLE).
- mthi/mtlo while IDLE: hi/lo<=wdata at the next edge. Both asserted together write the same wdata to both registers.
- mthi/mtlo while busy: the write is dropped and wr_err pulses for one cycle.
- start and mthi/mtlo in the same IDLE cycle: both take effect (the write lands now and the later capture overwrites it).
- Arithmetic: the product is truncated to no bits. hi=product[63:32], lo=product[31:0].

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit), latched with the operands on start.
  - When the latched signed_op=1, the captured value is mul_product - (mul_a[31] ? {mul_b,32'b0} : 0) - (mul_b[31] ? {mul_a,32'b0} : 0), mod 2^64. This gives the two's-complement signed product.
  - The correction is computed combinationally in the capture cycle. Latency is unchanged.
- Undefined:
  - signed_op port is absent.
  - Capture is always the raw unsigned product.

Decomposition:
- Shared package kgp_mul_pkg holds:
  - the state enum (IDLE=1'b0, SETTLE=1'b1);
  - the constants MUL_OP_W=32 and MUL_PROD_W=64;
  - the default SETTLE_CYCLES.
- One natural sub-module, mul_sign_fix: the combinational signed-correction logic. It is instantiated only under MUL_SIGNED_EN.
- The multiplier itself stays external, connected via mul_a, mul_b and mul_product.

Test Plan:
- Basic multiply: start with op_a=3, op_b=5, SETTLE_CYCLES=2 -> busy high for 2 cycles, done pulses in cycle 3, hi=0x00000000, lo=0x0000000F.
- Maximum operands: op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. With MUL_SIGNED_EN and signed_op=1 -> hi=0x00000000, lo=0x00000001.
- Start while busy: start op_a=2, op_b=2, then start op_a=7, op_b=7 the next cycle -> lo=4, a single done pulse, mul_a stays 2 throughout.
- Back-to-back: new start (6x7) asserted in the done cycle -> accepted, second done exactly SETTLE_CYCLES+1 cycles later, lo=42.
- Move-to-HI/LO: mthi wdata=0xDEADBEEF during busy -> wr_err pulse, hi unchanged. The same write in IDLE -> hi=0xDEADBEEF next cycle.
- Reset mid-operation: rst asserted one cycle after start -> next cycle busy=0, done never pulses, hi=lo=0, mul_a=mul_b=0.

Source files
------------

// File: rtl/kgp_mul_pkg.sv
// Shared types and constants for the KGP-RISC HI/LO multiply issue/capture stage.
package kgp_mul_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } mul_state_e;

  localparam int MUL_OP_W              = 32;
  localparam int MUL_PROD_W            = 64;
  localparam int DEFAULT_SETTLE_CYCLES = 2;

endpackage

// File: rtl/mul_sign_fix.sv
// Turns the unsigned 32x32 product into a two's-complement signed product.
// Only built when MUL_SIGNED_EN is defined.
`ifdef MUL_SIGNED_EN
module mul_sign_fix
  import kgp_mul_pkg::*;
(
  input  logic [MUL_OP_W-1:0]   a,
  input  logic [MUL_OP_W-1:0]   b,
  input  logic [MUL_PROD_W-1:0] product,
  input  logic                  signed_en,
  output logic [MUL_PROD_W-1:0] fixed
);

  logic [MUL_PROD_W-1:0] corr_a;
  logic [MUL_PROD_W-1:0] corr_b;

  // A negative operand contributes an extra 2^32 * other_operand to the unsigned product.
  always_comb begin
    corr_a = a[MUL_OP_W-1] ? {b, {MUL_OP_W{1'b0}}} : '0;
    corr_b = b[MUL_OP_W-1] ? {a, {MUL_OP_W{1'b0}}} : '0;
    fixed  = signed_en ? (product - corr_a - corr_b) : product;
  end

endmodule
`endif

// File: rtl/mul_hilo_unit.sv
// Multicycle issue/capture stage around an external 32x32->64 multiplier, with HI/LO registers.
// Optional signed multiply selected by the MUL_SIGNED_EN macro.
module mul_hilo_unit
  import kgp_mul_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int CNT_W         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MUL_SIGNED_EN
  input  logic                  signed_op,
`endif
  input  logic                  start,
  input  logic [MUL_OP_W-1:0]   op_a,
  input  logic [MUL_OP_W-1:0]   op_b,
  output logic [MUL_OP_W-1:0]   mul_a,
  output logic [MUL_OP_W-1:0]   mul_b,
  input  logic [MUL_PROD_W-1:0] mul_product,
  output logic                  busy,
  output logic                  done,
  output logic [MUL_OP_W-1:0]   hi,
  output logic [MUL_OP_W-1:0]   lo,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [MUL_OP_W-1:0]   wdata,
  output logic                  wr_err
);

  mul_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MUL_OP_W-1:0]   mul_a_q, mul_a_d;
  logic [MUL_OP_W-1:0]   mul_b_q, mul_b_d;
  logic [MUL_OP_W-1:0]   hi_q, hi_d;
  logic [MUL_OP_W-1:0]   lo_q, lo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_err_q, wr_err_d;
  logic [MUL_PROD_W-1:0] capture_val;

`ifdef MUL_SIGNED_EN
  logic signed_q, signed_d;

  mul_sign_fix u_sign_fix (
    .a         (mul_a_q),
    .b         (mul_b_q),
    .product   (mul_product),
    .signed_en (signed_q),
    .fixed     (capture_val)
  );

  always_comb begin
    signed_d = signed_q;
    if (state_q == IDLE && start) signed_d = signed_op;
  end

  always_ff @(posedge clk) begin
    if (rst) signed_q <= 1'b0;
    else     signed_q <= signed_d;
  end
`else
  assign capture_val = mul_product;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wr_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Direct writes land first; a capture started now will overwrite them later.
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          mul_a_d = op_a;
          mul_b_d = op_b;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
          busy_d  = 1'b1;
        end
      end
      SETTLE: begin
        if (mthi || mtlo) wr_err_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          hi_d    = capture_val[MUL_PROD_W-1:MUL_OP_W];
          lo_d    = capture_val[MUL_OP_W-1:0];
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Scoreboard bench for mul_hilo_unit: the driver predicts the visible state after every edge,
// a separate monitor compares it against the DUT. Honors MUL_SIGNED_EN.
module tb_mul_hilo_unit;
  import kgp_mul_pkg::*;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_product;
  logic        busy, done, wr_err;
  logic [31:0] hi, lo;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        signed_op;

  always #5 clk = ~clk;

  // The external multiplier the unit is wrapped around.
  assign mul_product = {32'b0, mul_a} * {32'b0, mul_b};

  mul_hilo_unit #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef MUL_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .wr_err      (wr_err)
  );

  typedef struct {
    int          edge_n;
    logic [31:0] hi, lo, ma, mb;
    logic        done, wr, busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   drv_edge = 0;

  // Reference model state, expressed as transactions in flight.
  bit          m_active = 0;
  int          m_cap_edge = 0;
  logic [63:0] m_prod = '0;
  logic [31:0] m_hi = '0, m_lo = '0, m_ma = '0, m_mb = '0;

  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    logic [63:0]        r;
    logic signed [63:0] sa, sb;
    r  = {32'b0, a} * {32'b0, b};
    sa = $signed(a);
    sb = $signed(b);
`ifdef MUL_SIGNED_EN
    if (sgn) r = sa * sb;
`else
    if (sgn && 1'b0) r = sa * sb;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input int e, input logic [31:0] got,
                             input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s edge %0d: got %h expected %h", name, e, got, expv);
    end
  endtask

  // Drive one cycle of inputs and record what the unit must show after that edge.
  task automatic applyStimulus(input logic r, input logic st, input logic [31:0] a,
                               input logic [31:0] b, input logic sgn, input logic wh,
                               input logic wl, input logic [31:0] wd);
    exp_t e;
    logic wr;
    logic dn;
    rst = r; start = st; op_a = a; op_b = b; signed_op = sgn;
    mthi = wh; mtlo = wl; wdata = wd;
    drv_edge++;
    wr = 1'b0;
    dn = 1'b0;
    if (r) begin
      m_active = 0; m_hi = '0; m_lo = '0; m_ma = '0; m_mb = '0;
    end else if (m_active) begin
      wr = wh | wl;
      if (drv_edge == m_cap_edge) begin
        m_hi = m_prod[63:32];
        m_lo = m_prod[31:0];
        dn = 1'b1;
        m_active = 0;
      end
    end else begin
      if (wh) m_hi = wd;
      if (wl) m_lo = wd;
      if (st) begin
        m_active   = 1;
        m_cap_edge = drv_edge + SETTLE;
        m_prod     = refProduct(a, b, sgn);
        m_ma = a;
        m_mb = b;
      end
    end
    e.edge_n = drv_edge;
    e.hi = m_hi; e.lo = m_lo; e.ma = m_ma; e.mb = m_mb;
    e.done = dn; e.wr = wr; e.busy = m_active;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idleStep();
    applyStimulus(0, 0, '0, '0, 0, 0, 0, '0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    applyStimulus(0, 1, a, b, sgn, 0, 0, '0);
  endtask

  // Monitor: pops one expectation per edge and compares every visible output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("hi", e.edge_n, hi, e.hi);
        checkOutput("lo", e.edge_n, lo, e.lo);
        checkOutput("mul_a", e.edge_n, mul_a, e.ma);
        checkOutput("mul_b", e.edge_n, mul_b, e.mb);
        checkOutput("done", e.edge_n, {31'b0, done}, {31'b0, e.done});
        checkOutput("wr_err", e.edge_n, {31'b0, wr_err}, {31'b0, e.wr});
        checkOutput("busy", e.edge_n, {31'b0, busy}, {31'b0, e.busy});
      end
    end
  end

  function automatic logic [31:0] pickOperand();
    logic [31:0] corners[4];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return $urandom();
  endfunction

  initial begin
    applyStimulus(1, 0, '0, '0, 0, 0, 0, '0);
    applyStimulus(1, 0, '0, '0, 0, 0, 0, '0);

    // Basic multiply and max operands (unsigned and signed view).
    issue(32'd3, 32'd5, 0);
    repeat (3) idleStep();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    repeat (3) idleStep();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    repeat (3) idleStep();

    // Start while busy is ignored.
    issue(32'd2, 32'd2, 0);
    issue(32'd7, 32'd7, 0);
    repeat (3) idleStep();

    // Back-to-back: second start lands in the done cycle.
    issue(32'd6, 32'd7, 0);
    idleStep();
    idleStep();
    issue(32'd6, 32'd7, 0);
    repeat (4) idleStep();

    // Move-to-HI while busy is dropped, while idle it lands.
    issue(32'd9, 32'd9, 0);
    applyStimulus(0, 0, '0, '0, 0, 1, 0, 32'hDEAD_BEEF);
    repeat (2) idleStep();
    applyStimulus(0, 0, '0, '0, 0, 1, 0, 32'hDEAD_BEEF);
    applyStimulus(0, 0, '0, '0, 0, 1, 1, 32'h1234_5678);
    // Start plus write in the same idle cycle.
    applyStimulus(0, 1, 32'd11, 32'd13, 0, 0, 1, 32'hCAFE_F00D);
    repeat (3) idleStep();

    // Reset one cycle after start aborts the multiply.
    issue(32'd100, 32'd200, 0);
    applyStimulus(1, 0, '0, '0, 0, 0, 0, '0);
    repeat (4) idleStep();

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                    pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom());
    end
    repeat (4) idleStep();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
